// File: rtl/htax_inport_rx_buffer.sv
// htax_inport_rx_buffer: per-VC store-and-forward receive buffer for one HTAX inport.
// Frames the incoming word stream, requests the decoded outport/VC, and streams granted packets out.
module htax_inport_rx_buffer #(
  parameter int NUM_PORTS  = 4,
  parameter int PORTS_LG   = 2,
  parameter int VC         = 2,
  parameter int WIDTH      = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_LG    = 4
) (
  input  logic                    clk,
  input  logic                    res_n,
  input  logic [WIDTH-1:0]        rx_data,
  input  logic [VC-1:0]           rx_sot,
  input  logic                    rx_eot,
  output logic [VC-1:0]           rx_credit,
  output logic [NUM_PORTS*VC-1:0] out_req,
  input  logic                    in_gnt,
  output logic [WIDTH-1:0]        out_data,
  output logic [VC-1:0]           out_sot,
  output logic                    out_eot,
  output logic                    err_overflow,
  output logic                    err_framing
);
  localparam int VC_LG = VC > 1 ? $clog2(VC) : 1;
  localparam int FL1 = FIFO_LG + 1;
  localparam int NR = NUM_PORTS * VC;
  localparam logic [FIFO_LG:0] FULL_LVL = FL1'(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, XFER = 2'd2;
  logic [WIDTH:0] mem [VC][FIFO_DEPTH];
  logic [FIFO_LG:0] wr_ptr [VC];
  logic [FIFO_LG:0] rd_ptr [VC];
  logic [FIFO_LG:0] pkt_cnt [VC];
  logic [1:0] state;
  logic [VC_LG-1:0] cur_vc, wr_vc, sel_vc, rr_ptr, pick_vc;
  logic [VC-1:0] full, inc, dec;
  logic [WIDTH:0] head, pick_head;
  logic in_pkt, start, we, wr_ok, pop, pick_ok;
  always_comb begin
    start = |rx_sot;
    wr_vc = cur_vc;
    for (int v = VC - 1; v >= 0; v--)
      if (rx_sot[v]) wr_vc = VC_LG'(v);
    we = start || in_pkt;
    pop = (state == REQ && in_gnt) || state == XFER;
    head = mem[sel_vc][rd_ptr[sel_vc][FIFO_LG-1:0]];
    for (int v = 0; v < VC; v++) full[v] = (wr_ptr[v] - rd_ptr[v]) == FULL_LVL;
    // a pop on the same VC frees a slot in the same cycle, so a full FIFO can still accept
    wr_ok = we && (!full[wr_vc] || (pop && sel_vc == wr_vc));
    for (int v = 0; v < VC; v++) begin
      inc[v] = wr_ok && rx_eot && wr_vc == VC_LG'(v);
      dec[v] = pop && head[WIDTH] && sel_vc == VC_LG'(v);
    end
    pick_ok = 1'b0;
    pick_vc = rr_ptr;
    for (int i = VC - 1; i >= 0; i--)
      if (pkt_cnt[(int'(rr_ptr) + i) % VC] != '0) begin
        pick_ok = 1'b1;
        pick_vc = VC_LG'((int'(rr_ptr) + i) % VC);
      end
    pick_head = mem[pick_vc][rd_ptr[pick_vc][FIFO_LG-1:0]];
    rx_credit = pop ? VC'(1) << sel_vc : '0;
  end
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_vc][wr_ptr[wr_vc][FIFO_LG-1:0]] <= {rx_eot, rx_data};
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      in_pkt <= 1'b0;
      cur_vc <= '0;
      err_framing <= 1'b0;
      err_overflow <= 1'b0;
      for (int v = 0; v < VC; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        pkt_cnt[v] <= '0;
      end
    end else begin
      if (we) in_pkt <= !rx_eot;
      if (start) cur_vc <= wr_vc;
      if ((in_pkt && start) || (!in_pkt && !start && rx_eot)) err_framing <= 1'b1;
      if (we && !wr_ok) err_overflow <= 1'b1;
      for (int v = 0; v < VC; v++) begin
        wr_ptr[v] <= wr_ptr[v] + FL1'(wr_ok && wr_vc == VC_LG'(v));
        rd_ptr[v] <= rd_ptr[v] + FL1'(pop && sel_vc == VC_LG'(v));
        pkt_cnt[v] <= pkt_cnt[v] + FL1'(inc[v]) - FL1'(dec[v]);
      end
    end
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      state <= IDLE;
      sel_vc <= '0;
      rr_ptr <= '0;
      out_req <= '0;
      out_data <= '0;
      out_sot <= '0;
      out_eot <= 1'b0;
    end else begin
      out_sot <= '0;
      out_eot <= 1'b0;
      if (state == IDLE && pick_ok) begin
        sel_vc <= pick_vc;
        out_req <= NR'(1) << (int'(pick_head[PORTS_LG-1:0]) * VC + int'(pick_vc));
        state <= REQ;
      end
      if (pop) begin
        out_req <= '0;
        out_data <= head[WIDTH-1:0];
        out_sot <= state == REQ ? VC'(1) << sel_vc : '0;
        out_eot <= head[WIDTH];
        state <= head[WIDTH] ? IDLE : XFER;
        if (head[WIDTH]) rr_ptr <= VC_LG'((int'(sel_vc) + 1) % VC);
      end
    end
endmodule

// File: tb/tb_htax_inport_rx_buffer.sv
// tb_htax_inport_rx_buffer: scoreboard bench; expected words queued at send, retired as the DUT forwards them.
module tb_htax_inport_rx_buffer;
  logic clk, res_n, rx_eot, in_gnt, out_eot, err_overflow, err_framing;
  logic [63:0] rx_data, out_data;
  logic [1:0] rx_sot, rx_credit, out_sot;
  logic [7:0] out_req, prev_req;
  typedef struct {int vc; bit first; bit eot; logic [63:0] data;} sb_t;
  sb_t sb[$];
  int served[$];
  int n_chk = 0, n_err = 0, gnt_delay = 0, mon_vc = 0;
  int cred[2];
  bit mon_in = 0;
  htax_inport_rx_buffer dut (
    .clk(clk), .res_n(res_n), .rx_data(rx_data), .rx_sot(rx_sot), .rx_eot(rx_eot),
    .rx_credit(rx_credit), .out_req(out_req), .in_gnt(in_gnt), .out_data(out_data),
    .out_sot(out_sot), .out_eot(out_eot), .err_overflow(err_overflow), .err_framing(err_framing)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // grant driver: one-cycle in_gnt after gnt_delay cycles of visible request
  initial begin
    int wc = 0;
    in_gnt = 0;
    forever begin
      @(negedge clk);
      if (!res_n || in_gnt) begin
        in_gnt = 0;
        wc = 0;
      end else if (out_req != 0) begin
        if (wc >= gnt_delay) in_gnt = 1;
        else wc++;
      end
    end
  end
  always @(negedge clk) begin
    int idx;
    int rv;
    if (res_n) begin
      for (int v = 0; v < 2; v++) cred[v] += int'(rx_credit[v]);
      if (out_req != 0 && prev_req == 0) begin
        check("req_onehot", 64'($countones(out_req)), 64'd1);
        rv = 0;
        for (int b = 0; b < 8; b++) if (out_req[b]) rv = b;
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
          if (idx < 0 && sb[i].vc == rv % 2) idx = i;
        check("req_dest", idx < 0 ? 64'hdead : {61'd0, sb[idx].first, sb[idx].data[1:0]},
              {61'd0, 1'b1, 2'(rv / 2)});
      end
      if (out_eot && out_req != 0) check("req_gap", {56'd0, out_req}, 64'd0);
      if (out_sot != 0) begin
        check("sot_onehot", 64'($countones(out_sot)), 64'd1);
        mon_vc = out_sot[1] ? 1 : 0;
        served.push_back(mon_vc);
        mon_in = 1;
      end
      if (mon_in) begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
          if (idx < 0 && sb[i].vc == mon_vc) idx = i;
        if (idx < 0) check("extra_word", out_data, 64'hffff_ffff_ffff_ffff);
        else begin
          check("word_data", out_data, sb[idx].data);
          check("word_eot", 64'(out_eot), 64'(sb[idx].eot));
          check("word_sot", 64'(out_sot), sb[idx].first ? 64'(2'b01 << mon_vc) : 64'd0);
          sb.delete(idx);
        end
        if (out_eot) mon_in = 0;
      end else if (out_eot) check("stray_eot", 64'(out_eot), 64'd0);
    end
    prev_req = res_n ? out_req : 8'd0;
  end
  task automatic drive_word(input logic [1:0] sot, input logic eot, input logic [63:0] d);
    @(negedge clk);
    rx_sot = sot;
    rx_eot = eot;
    rx_data = d;
  endtask
  task automatic idle_rx();
    @(negedge clk);
    rx_sot = 0;
    rx_eot = 0;
  endtask
  task automatic send_pkt(input int vc, input int port, input int len, input bit push);
    logic [63:0] d;
    for (int w = 0; w < len; w++) begin
      d = {$urandom(), $urandom()};
      d[1:0] = 2'(port);
      drive_word(w == 0 ? 2'(2'b01 << vc) : 2'b00, w == len - 1, d);
      if (push) sb.push_back('{vc, w == 0, w == len - 1, d});
    end
    idle_rx();
  endtask
  task automatic wait_drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || out_req != 0 || mon_in) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(n < 3000), 64'd1);
    repeat (3) @(negedge clk);
  endtask
  initial begin
    int n, reqs;
    res_n = 0;
    rx_sot = 0;
    rx_eot = 0;
    rx_data = 0;
    prev_req = 0;
    cred = '{0, 0};
    repeat (3) @(negedge clk);
    res_n = 1;
    @(negedge clk);
    check("rst_req", {56'd0, out_req}, 64'd0);
    check("rst_out", {out_data[61:0], out_sot}, 64'd0);
    check("rst_flags", {61'd0, out_eot, err_overflow, err_framing}, 64'd0);
    check("rst_credit", 64'(rx_credit), 64'd0);
    // single word packet, VC0 to port 2
    drive_word(2'b01, 1, 64'h0123_4567_89ab_cd02);
    sb.push_back('{0, 1'b1, 1'b1, 64'h0123_4567_89ab_cd02});
    idle_rx();
    wait_drain("t1_drain");
    check("t1_credit", 64'(cred[0]), 64'd1);
    // 4-word packet, VC1 to port 3, delayed grant
    gnt_delay = 5;
    send_pkt(1, 3, 4, 1);
    wait_drain("t2_drain");
    check("t2_credit", 64'(cred[1]), 64'd4);
    // round robin: VC0 busy while VC1 then VC0 packets arrive
    served.delete();
    gnt_delay = 30;
    send_pkt(0, 1, 3, 1);
    send_pkt(1, 0, 2, 1);
    send_pkt(0, 2, 2, 1);
    wait_drain("t3_drain");
    check("t3_count", 64'(served.size()), 64'd3);
    if (served.size() == 3) check("t3_order", {served[0][7:0], served[1][7:0], served[2][7:0]}, 64'h00_01_00);
    check("t3_no_err", {62'd0, err_overflow, err_framing}, 64'd0);
    // overflow: 16-word packet fills VC0, 17th word dropped
    cred = '{0, 0};
    gnt_delay = 60;
    send_pkt(0, 1, 16, 1);
    send_pkt(0, 3, 1, 0);
    check("t4_overflow", 64'(err_overflow), 64'd1);
    wait_drain("t4_drain");
    check("t4_credit", 64'(cred[0]), 64'd16);
    // framing: VC0 packet interrupted by VC1 start
    gnt_delay = 0;
    drive_word(2'b01, 0, 64'h5555_0000_0000_0001);
    send_pkt(1, 1, 2, 1);
    check("t5_framing", 64'(err_framing), 64'd1);
    wait_drain("t5_drain");
    // reset during third forwarded word
    send_pkt(1, 0, 5, 1);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (out_sot == 0 && n < 200);
    check("t6_start", 64'(n < 200), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    res_n = 0;
    #1;
    check("t6_req", {56'd0, out_req}, 64'd0);
    check("t6_data", out_data, 64'd0);
    check("t6_sot_eot_cred", {59'd0, out_sot, out_eot, rx_credit}, 64'd0);
    check("t6_errs", {62'd0, err_overflow, err_framing}, 64'd0);
    sb.delete();
    mon_in = 0;
    repeat (3) @(negedge clk);
    res_n = 1;
    reqs = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_req != 0) reqs++;
    end
    check("t6_noreq", 64'(reqs), 64'd0);
    send_pkt(0, 3, 3, 1);
    wait_drain("t6_drain");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
